mcs6530_bus_master: RTL and testbench
=====================================

Name: mcs6530_bus_master

Overview:
- Synchronous 6502-side bus initiator that drives the RRIOT pin interface (A[9:0], RS0, R/W, data bus, RES) and completes read/write cycles against the mcs6530 responder.
- Accepts queued commands over a valid/ready interface, sequences one bus cycle at a time, returns read data in order, generates the bus reset pulse and tracks the IRQ line.
- Used as the CPU-side partner for bring-up, loopback boards and simulation benches.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, range 2..16.
- READ_LATENCY, 2, phi2 cycles from the end of the address cycle until read data is sampled; range 1..7.
- RESET_CYCLES, 8, phi2 cycles bus_rst_n is held low after rst_n deasserts; range 1..255.

Ports:
- phi2  in  1  bus clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept; equals !fifo_full.
- cmd_we  in  1  1=write, 0=read.
- cmd_rs0  in  1  RS0 value for the cycle.
- cmd_addr  in  10  address.
- cmd_data  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_addr  out  10  address of the completed read.
- rsp_data  out  8  read data.
- bus_A  out  10  address pins.
- bus_RS0  out  1  RS0 pin.
- bus_we_n  out  1  R/W pin; 0 = write.
- bus_DO  out  8  data driven during writes.
- bus_OE  out  1  data pin output enable.
- bus_DI  in  8  data pins as seen from the master.
- bus_rst_n  out  1  RES pin.
- irq_n  in  1  responder IRQ, active-low.
- irq_pending  out  1  registered ~irq_n.
- irq_count  out  8  falling edges seen on irq_n; saturates at 255.
- busy  out  1  high if the FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_addr=0, rsp_data=0, bus_A=0, bus_RS0=0, bus_we_n=1, bus_DO=0, bus_OE=0, bus_rst_n=0, irq_pending=0, irq_count=0, busy=1.
- Reset clears the FIFO. The state becomes RST_HOLD.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pushes are accepted in any state, including RST_HOLD.
  - A simultaneous push and pop on a full FIFO is not allowed; cmd_ready reflects the registered full flag only.
  - Commands execute in order.
- FSM states:
  - RST_HOLD:
    - bus_rst_n=0.
    - A counter runs RESET_CYCLES cycles.
    - On the edge ending the last cycle: bus_rst_n<=1 and go to IDLE.
    - No bus cycles are issued in this state.
  - IDLE:
    - Bus idles: bus_we_n=1, bus_OE=0; bus_A and bus_RS0 hold their last values.
    - If the FIFO is non-empty: pop and load bus_A, bus_RS0, bus_we_n, bus_DO, bus_OE at the same edge, then go to WRITE or READ.
  - WRITE:
    - Exactly one cycle: bus_we_n=0, bus_OE=1, bus_DO=data.
    - At the ending edge, pop the next command directly if one is present (back-to-back writes at 1/cycle); otherwise return to IDLE with bus_OE<=0 and bus_we_n<=1.
  - READ:
    - The address cycle (T0) plus READ_LATENCY wait cycles.
    - bus_A and bus_RS0 are held, bus_we_n=1, bus_OE=0 throughout.
    - bus_DI is sampled at the edge ending cycle T(READ_LATENCY): rsp_data<=bus_DI, rsp_addr<=address, rsp_valid<=1 for exactly one cycle.
    - The next command may be popped at that same edge.
- Read cost is READ_LATENCY+1 cycles; the response appears READ_LATENCY+1 cycles after the address first appears. There is no rsp backpressure.
- Bus contention rule: bus_OE is never 1 during any READ cycle. Write-after-read is safe because the read window fully elapses first.
- IRQ:
  - irq_pending<=~irq_n every cycle.
  - irq_count increments when irq_pending goes 0->1, saturating at 255.
  - It is counted in all states, including RST_HOLD.
- Reset mid-operation: any in-flight read is dropped with no rsp_valid. Queued commands are discarded and RST_HOLD restarts.

Test Plan:
- Reset: release rst_n with RESET_CYCLES=8 -> bus_rst_n low for exactly 8 phi2 rises then 1. A command pushed during the hold is issued in the first IDLE cycle after release.
- Back-to-back writes: push writes (0x080,0x55),(0x081,0xAA),(0x082,0x0F) -> three consecutive cycles with bus_we_n=0, bus_OE=1, bus_DO=55/AA/0F. Then bus_OE=0, bus_we_n=1.
- Read latency: READ_LATENCY=2, read 0x3F3 with a stub returning 0xC3 on bus_DI two cycles after the address cycle -> rsp_valid pulses once, 3 cycles after bus_A=0x3F3, rsp_data=0xC3, rsp_addr=0x3F3. bus_OE stays 0 throughout.
- Queue full: with FIFO_DEPTH=4 and the FSM blocked by a READ_LATENCY=7 read, push 5 commands -> cmd_ready=0 after the 4th accept. The 5th is held until a pop. All commands execute in push order.
- IRQ: toggle irq_n low/high 300 times -> irq_count=255 (saturated). A level held low gives a single count.
- Reset mid-read: assert rst_n during READ wait cycle 1 -> no rsp_valid, FIFO empty, bus_rst_n=0, all outputs at their reset values.

Source files
------------

// File: rtl/mcs6530_bus_master.sv
// mcs6530_bus_master: 6502-side initiator for the RRIOT pin bus.
// Queues commands, runs one bus cycle at a time, returns reads in order.
module mcs6530_bus_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int RESET_CYCLES = 8
) (
  input  logic       phi2,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic       cmd_rs0,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [9:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic [9:0] bus_A,
  output logic       bus_RS0,
  output logic       bus_we_n,
  output logic [7:0] bus_DO,
  output logic       bus_OE,
  input  logic [7:0] bus_DI,
  output logic       bus_rst_n,
  input  logic       irq_n,
  output logic       irq_pending,
  output logic [7:0] irq_count,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_RST_HOLD,
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t state_q, state_d;

  logic [19:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  logic [19:0]   head;
  logic          head_we, head_rs0;
  logic [9:0]    head_addr;
  logic [7:0]    head_data;

  logic [7:0]    rst_cnt_q, rst_cnt_d;
  logic [2:0]    rd_cnt_q, rd_cnt_d;
  logic          leave;

  logic [9:0]    bus_a_q, bus_a_d;
  logic          rs0_q, rs0_d;
  logic          we_n_q, we_n_d;
  logic [7:0]    do_q, do_d;
  logic          oe_q, oe_d;
  logic          bus_rst_n_q, bus_rst_n_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [9:0]    rsp_addr_q, rsp_addr_d;
  logic [7:0]    rsp_data_q, rsp_data_d;

  logic          irq_pend_q, irq_pend_d;
  logic [7:0]    irq_cnt_q, irq_cnt_d;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = cmd_valid && !full;

  assign head      = fifo_q[rd_ptr_q];
  assign head_we   = head[19];
  assign head_rs0  = head[18];
  assign head_addr = head[17:8];
  assign head_data = head[7:0];

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge phi2) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_we, cmd_rs0, cmd_addr, cmd_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    bus_a_d     = bus_a_q;
    rs0_d       = rs0_q;
    we_n_d      = we_n_q;
    do_d        = do_q;
    oe_d        = oe_q;
    bus_rst_n_d = bus_rst_n_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    leave       = 1'b0;

    unique case (state_q)
      S_RST_HOLD: begin
        if (rst_cnt_q == 8'(RESET_CYCLES - 1)) begin
          state_d     = S_IDLE;
          bus_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        we_n_d = 1'b1;
        oe_d   = 1'b0;
      end
      S_WRITE: begin
        leave = 1'b1;
      end
      S_READ: begin
        if (rd_cnt_q == 3'(READ_LATENCY)) begin
          leave       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = bus_a_q;
          rsp_data_d  = bus_DI;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
    endcase

    // Issue straight from the end of a cycle so writes run 1 per phi2.
    if ((state_q == S_IDLE || leave) && !empty) begin
      pop      = 1'b1;
      bus_a_d  = head_addr;
      rs0_d    = head_rs0;
      we_n_d   = ~head_we;
      oe_d     = head_we;
      rd_cnt_d = 3'd0;
      state_d  = head_we ? S_WRITE : S_READ;
      if (head_we) begin
        do_d = head_data;
      end
    end else if (leave) begin
      state_d = S_IDLE;
      we_n_d  = 1'b1;
      oe_d    = 1'b0;
    end
  end

  always_comb begin
    irq_pend_d = ~irq_n;
    irq_cnt_d  = irq_cnt_q;
    if (~irq_n && !irq_pend_q && irq_cnt_q != 8'hFF) begin
      irq_cnt_d = irq_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_HOLD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      bus_a_q     <= '0;
      rs0_q       <= 1'b0;
      we_n_q      <= 1'b1;
      do_q        <= '0;
      oe_q        <= 1'b0;
      bus_rst_n_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      irq_pend_q  <= 1'b0;
      irq_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bus_a_q     <= bus_a_d;
      rs0_q       <= rs0_d;
      we_n_q      <= we_n_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
      bus_rst_n_q <= bus_rst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      irq_pend_q  <= irq_pend_d;
      irq_cnt_q   <= irq_cnt_d;
    end
  end

  assign cmd_ready   = !full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign bus_A       = bus_a_q;
  assign bus_RS0     = rs0_q;
  assign bus_we_n    = we_n_q;
  assign bus_DO      = do_q;
  assign bus_OE      = oe_q;
  assign bus_rst_n   = bus_rst_n_q;
  assign irq_pending = irq_pend_q;
  assign irq_count   = irq_cnt_q;
  assign busy        = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Bench for mcs6530_bus_master: transaction-level schedule model,
// per-cycle output compare, and directed literal checks.
module tb_mcs6530_bus_master;

  localparam int DEPTH = 4;
  localparam int RL    = 2;
  localparam int RC    = 8;

  logic       phi2;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_we, cmd_rs0;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [9:0] rsp_addr;
  logic [7:0] rsp_data;
  logic [9:0] bus_A;
  logic       bus_RS0, bus_we_n, bus_OE, bus_rst_n;
  logic [7:0] bus_DO, bus_DI;
  logic       irq_n, irq_pending;
  logic [7:0] irq_count;
  logic       busy;

  mcs6530_bus_master #(
    .FIFO_DEPTH  (DEPTH),
    .READ_LATENCY(RL),
    .RESET_CYCLES(RC)
  ) dut (
    .phi2       (phi2),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_rs0    (cmd_rs0),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data),
    .bus_A      (bus_A),
    .bus_RS0    (bus_RS0),
    .bus_we_n   (bus_we_n),
    .bus_DO     (bus_DO),
    .bus_OE     (bus_OE),
    .bus_DI     (bus_DI),
    .bus_rst_n  (bus_rst_n),
    .irq_n      (irq_n),
    .irq_pending(irq_pending),
    .irq_count  (irq_count),
    .busy       (busy)
  );

  initial begin
    phi2 = 1'b0;
    forever #5 phi2 = ~phi2;
  end

  typedef struct {
    int         push_e;
    int         issue_e;
    int         end_e;
    bit         we;
    bit         rs0;
    logic [9:0] addr;
    logic [7:0] data;
  } op_t;

  op_t        ops[$];
  int         cyc;
  int         last_end;
  bit         acc;
  bit         pend_m;
  int         cnt_m;
  logic [7:0] mmem [1024];
  logic [7:0] rmem [1024];

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rsp_log[$];
  logic [7:0] wlog[$];
  int         wcyc[$];
  int         first_we = -1;
  int         rise_c = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  assign bus_DI = rmem[bus_A];

  // Responder: plain 1K RAM on the pins.
  initial begin
    for (int i = 0; i < 1024; i++) rmem[i] = 8'(i) ^ 8'h5A;
    rmem[10'h3F3] = 8'hC3;
    forever begin
      @(posedge phi2);
      if (!bus_we_n && bus_OE) rmem[bus_A] = bus_DO;
    end
  end

  function automatic int occ_pre(int n);
    int c = 0;
    foreach (ops[i]) if (ops[i].push_e < n && ops[i].issue_e >= n) c++;
    return c;
  endfunction

  // Model: each command occupies the bus for 1 (write) or RL+1 (read)
  // cycles, starting at the earliest edge it may legally be issued.
  initial begin
    int iss;
    op_t o;
    for (int i = 0; i < 1024; i++) mmem[i] = 8'(i) ^ 8'h5A;
    mmem[10'h3F3] = 8'hC3;
    cyc = 0; last_end = 0; acc = 0; pend_m = 0; cnt_m = 0;
    forever begin
      @(posedge phi2 or negedge rst_n);
      if (!rst_n) begin
        ops.delete();
        cyc = 0; last_end = 0; acc = 0; pend_m = 0; cnt_m = 0;
      end else begin
        cyc++;
        acc = 0;
        foreach (ops[i])
          if (ops[i].we && ops[i].end_e == cyc) mmem[ops[i].addr] = ops[i].data;
        if (cmd_valid && occ_pre(cyc) < DEPTH) begin
          acc = 1;
          iss = last_end;
          if (cyc + 1 > iss) iss = cyc + 1;
          if (RC + 1 > iss) iss = RC + 1;
          o.push_e = cyc; o.issue_e = iss;
          o.end_e = iss + (cmd_we ? 1 : RL + 1);
          o.we = cmd_we; o.rs0 = cmd_rs0; o.addr = cmd_addr; o.data = cmd_data;
          ops.push_back(o);
          last_end = o.end_e;
        end
        if (!irq_n && !pend_m && cnt_m < 255) cnt_m++;
        pend_m = !irq_n;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    int n, cur, occ;
    bit rv, act, bz;
    logic [9:0] ra;
    logic [7:0] rd;
    forever begin
      @(negedge phi2);
      n = cyc; cur = -1; occ = 0; rv = 0; ra = '0; rd = '0;
      bz = (n < RC);
      foreach (ops[i]) begin
        if (ops[i].issue_e <= n) cur = i;
        if (!ops[i].we && ops[i].end_e == n) begin
          rv = 1; ra = ops[i].addr; rd = mmem[ops[i].addr];
        end
        if (ops[i].push_e <= n && n < ops[i].end_e) bz = 1;
        if (ops[i].push_e <= n && ops[i].issue_e > n) occ++;
      end
      act = (cur >= 0) && (n < ops[cur >= 0 ? cur : 0].end_e)
            && ops[cur >= 0 ? cur : 0].we;
      chk("cmd_ready", cmd_ready, occ < DEPTH);
      chk("bus_rst_n", bus_rst_n, n >= RC);
      chk("busy", busy, bz);
      chk("bus_A", bus_A, cur >= 0 ? ops[cur].addr : 10'h0);
      chk("bus_RS0", bus_RS0, cur >= 0 ? ops[cur].rs0 : 1'b0);
      chk("bus_we_n", bus_we_n, !act);
      chk("bus_OE", bus_OE, act);
      if (act) chk("bus_DO", bus_DO, ops[cur].data);
      chk("rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("rsp_addr", rsp_addr, ra);
        chk("rsp_data", rsp_data, rd);
      end
      chk("irq_pending", irq_pending, pend_m);
      chk("irq_count", irq_count, cnt_m);
      if (rsp_valid) rsp_log.push_back(rsp_data);
      if (bus_OE) begin
        wlog.push_back(bus_DO);
        wcyc.push_back(n);
      end
      if (!bus_we_n && first_we < 0) first_we = n;
      if (bus_rst_n && rise_c < 0) rise_c = n;
    end
  end

  task automatic push(input bit we, input bit rs0, input logic [9:0] a,
                      input logic [7:0] d);
    bit ok = 0;
    cmd_valid = 1; cmd_we = we; cmd_rs0 = rs0; cmd_addr = a; cmd_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge phi2);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    cmd_valid = 0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 60; i++) begin
      @(negedge phi2);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int t0, t1, sz;
    logic [7:0] v0, v1, v2;
    rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_rs0 = 0;
    cmd_addr = '0; cmd_data = '0; irq_n = 1;
    repeat (3) @(negedge phi2);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_addr", rsp_addr, 10'h000);
    chk("rst_bus_DO", bus_DO, 8'h00);
    chk("rst_bus_rst_n", bus_rst_n, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1;

    // Fill the queue while the bus reset is still held.
    push(1, 0, 10'h100, 8'h11);
    push(1, 1, 10'h101, 8'h22);
    push(0, 0, 10'h100, 8'h00);
    push(1, 0, 10'h102, 8'h33);
    chk("full_ready", cmd_ready, 0);
    push(0, 1, 10'h101, 8'h00);
    idle_wait();
    chk("rst_rise_cyc", rise_c, 8);
    chk("first_issue_cyc", first_we, 9);
    chk("order_rsp_cnt", rsp_log.size(), 2);
    v0 = rsp_log.size() > 0 ? rsp_log[0] : 8'hxx;
    v1 = rsp_log.size() > 1 ? rsp_log[1] : 8'hxx;
    chk("order_rsp0", v0, 8'h11);
    chk("order_rsp1", v1, 8'h22);

    // Back-to-back writes.
    wlog.delete(); wcyc.delete();
    push(1, 0, 10'h080, 8'h55);
    push(1, 0, 10'h081, 8'hAA);
    push(1, 0, 10'h082, 8'h0F);
    idle_wait();
    chk("b2b_cnt", wlog.size(), 3);
    v0 = wlog.size() > 0 ? wlog[0] : 8'hxx;
    v1 = wlog.size() > 1 ? wlog[1] : 8'hxx;
    v2 = wlog.size() > 2 ? wlog[2] : 8'hxx;
    chk("b2b_d0", v0, 8'h55);
    chk("b2b_d1", v1, 8'hAA);
    chk("b2b_d2", v2, 8'h0F);
    chk("b2b_span", wcyc.size() > 2 ? wcyc[2] - wcyc[0] : -1, 2);
    chk("b2b_after_oe", bus_OE, 0);

    // Read latency against the stub value at 0x3F3.
    t0 = -100; t1 = -1;
    push(0, 1, 10'h3F3, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if (bus_A == 10'h3F3) begin
        t0 = cyc;
        break;
      end
      @(negedge phi2);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge phi2);
      if (rsp_valid) begin
        t1 = cyc;
        break;
      end
    end
    chk("rd_latency", t1 - t0, 3);
    chk("rd_data", rsp_data, 8'hC3);
    chk("rd_addr", rsp_addr, 10'h3F3);
    idle_wait();
    push(0, 0, 10'h081, 8'h00);
    idle_wait();
    chk("rd_back", rsp_log.size() > 0 ? rsp_log[rsp_log.size() - 1] : 8'hxx, 8'hAA);

    // IRQ: a held level counts once, then saturation.
    irq_n = 0;
    repeat (5) @(negedge phi2);
    irq_n = 1;
    repeat (2) @(negedge phi2);
    chk("irq_level", irq_count, 8'd1);
    for (int i = 0; i < 300; i++) begin
      irq_n = 0;
      @(negedge phi2);
      irq_n = 1;
      @(negedge phi2);
    end
    chk("irq_sat", irq_count, 8'd255);

    // Reset during the first read wait cycle.
    sz = rsp_log.size();
    push(0, 0, 10'h200, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if (bus_A == 10'h200) break;
      @(negedge phi2);
    end
    @(posedge phi2);
    #2 rst_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge phi2);
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_bus_rst_n", bus_rst_n, 0);
      chk("mr_cmd_ready", cmd_ready, 1);
      chk("mr_bus_A", bus_A, 10'h000);
      chk("mr_bus_we_n", bus_we_n, 1);
      chk("mr_irq_count", irq_count, 8'd0);
    end
    rst_n = 1;
    repeat (12) @(negedge phi2);
    chk("mr_idle", busy, 0);
    chk("mr_bus_rst_n_up", bus_rst_n, 1);
    chk("mr_no_rsp", rsp_log.size(), sz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
